// File: rtl/clear_line_tran.sv
// ---------------------------------------------------------------------------
// clear_line_tran
//   Line-clear transition sequencer for the Tetris game engine.
//   When enabled, every full row of the 20 x COLS board is written twice
//   through the board-memory write port. The first pass writes the colour of
//   the locking piece (flash effect). The second pass writes EMPTY_CODE.
//   clear_line_done is raised when both passes are finished. Row compaction
//   is done by a separate block after this one.
//
//   Ports
//     clk             : system clock, rising edge
//     reset           : asynchronous, active-low reset
//     enable          : level-sensitive start/hold request from the game FSM
//     line_full[0:19] : row-full flags, index 0 = top row, 19 = bottom row
//     piece_type      : colour code used in the first pass
//     pos_i           : row address to board memory
//     pos_j           : column address to board memory
//     clear_line_done : high while the sequence is complete
//     read            : 1 = read/idle, 0 = write strobe
//     write_data      : cell code to write
//
//   All outputs are registered from the current state, so they trail the
//   state register by one clock.
// ---------------------------------------------------------------------------
module clear_line_tran #(
   parameter int         COLS       = 10,
   parameter logic [2:0] EMPTY_CODE = 3'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [0:19] line_full,
   input  logic [2:0]  piece_type,
   output logic [4:0]  pos_i,
   output logic [4:0]  pos_j,
   output logic        clear_line_done,
   output logic        read,
   output logic [2:0]  write_data
);

   localparam logic [4:0] LAST_COL = 5'(COLS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [0:19] latch_q, latch_d;   // rows captured at start, reloaded for pass 2
   logic [0:19] wm_q, wm_d;         // rows still to be visited in this pass
   logic        pass2_q, pass2_d;   // 0 = colour pass, 1 = empty pass
   logic [4:0]  row_q, row_d;
   logic [4:0]  col_q, col_d;

   logic [4:0]  pos_i_q, pos_i_d;
   logic [4:0]  pos_j_q, pos_j_d;
   logic        done_q, done_d;
   logic        read_q, read_d;
   logic [2:0]  wdata_q, wdata_d;

   // Lowest set index in the working mask (topmost remaining full row).
   logic        found;
   logic [4:0]  first_row;

   always_comb begin
      found     = 1'b0;
      first_row = 5'd0;
      // Scanning downwards lets the lowest index win.
      for (int i = 19; i >= 0; i--) begin
         if (wm_q[i]) begin
            found     = 1'b1;
            first_row = 5'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // State register (plus datapath registers)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         latch_q <= '0;
         wm_q    <= '0;
         pass2_q <= 1'b0;
         row_q   <= 5'd0;
         col_q   <= 5'd0;
         pos_i_q <= 5'd0;
         pos_j_q <= 5'd0;
         done_q  <= 1'b0;
         read_q  <= 1'b1;
         wdata_q <= 3'd0;
      end else begin
         state_q <= state_d;
         latch_q <= latch_d;
         wm_q    <= wm_d;
         pass2_q <= pass2_d;
         row_q   <= row_d;
         col_q   <= col_d;
         pos_i_q <= pos_i_d;
         pos_j_q <= pos_j_d;
         done_q  <= done_d;
         read_q  <= read_d;
         wdata_q <= wdata_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      latch_d = latch_q;
      wm_d    = wm_q;
      pass2_d = pass2_q;
      row_d   = row_q;
      col_d   = col_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               // line_full is sampled only here; the rest of the sequence
               // works from the captured copy.
               latch_d = line_full;
               wm_d    = line_full;
               pass2_d = 1'b0;
               state_d = SCAN;
            end
         end

         SCAN: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (found) begin
               row_d   = first_row;
               col_d   = 5'd0;
               state_d = WRITE;
            end else if (!pass2_q) begin
               wm_d    = latch_q;
               pass2_d = 1'b1;
            end else begin
               state_d = DONE;
            end
         end

         WRITE: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (col_q == LAST_COL) begin
               wm_d[row_q] = 1'b0;
               state_d     = SCAN;
            end else begin
               col_d = col_q + 5'd1;
            end
         end

         DONE: begin
            if (!enable) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output logic (registered in the state register process)
   // ---------------------------------------------------------------------
   always_comb begin
      pos_i_d = pos_i_q;
      pos_j_d = pos_j_q;
      done_d  = 1'b0;
      read_d  = 1'b1;
      wdata_d = wdata_q;

      // A dropped enable forces idle outputs on the same edge that sends
      // the FSM back to IDLE.
      case (state_q)
         SCAN: begin
            if (enable && found) begin
               pos_i_d = first_row;
               pos_j_d = 5'd0;
            end
         end

         WRITE: begin
            if (enable) begin
               read_d  = 1'b0;
               pos_i_d = row_q;
               pos_j_d = col_q;
               wdata_d = pass2_q ? EMPTY_CODE : piece_type;
            end
         end

         DONE: begin
            done_d = enable;
         end

         default: ;
      endcase
   end

   assign pos_i           = pos_i_q;
   assign pos_j           = pos_j_q;
   assign clear_line_done = done_q;
   assign read            = read_q;
   assign write_data      = wdata_q;

endmodule

// File: tb/tb_clear_line_tran.sv
// ---------------------------------------------------------------------------
// tb_clear_line_tran
//   Directed testbench for clear_line_tran (COLS=10, EMPTY_CODE=0).
//   The expected write sequence for each run is built from the row mask
//   handed to the run; the expected done latency is 1 + 2*(11N+1) edges.
// ---------------------------------------------------------------------------
module tb_clear_line_tran;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [0:19] line_full;
   logic [2:0]  piece_type;
   logic [4:0]  pos_i;
   logic [4:0]  pos_j;
   logic        clear_line_done;
   logic        read;
   logic [2:0]  write_data;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   clear_line_tran dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .line_full       (line_full),
      .piece_type      (piece_type),
      .pos_i           (pos_i),
      .pos_j           (pos_j),
      .clear_line_done (clear_line_done),
      .read            (read),
      .write_data      (write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input int got, input int exp);
      vec_cnt++;
      if (got != exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock edge, then sample 1 time unit later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs a full sequence; optionally changes line_full at edge change_at or
   // drops enable at edge abort_at (edges counted after the enabling edge).
   task automatic run_seq(input string name, input logic [0:19] lf,
                          input logic [2:0] pc, input int change_at,
                          input int abort_at);
      int ei[$];
      int ej[$];
      int ed[$];
      int n;
      int idx;
      int done_t;
      n = 0;
      for (int r = 0; r < 20; r++) if (lf[r]) n++;
      for (int p = 0; p < 2; p++)
         for (int r = 0; r < 20; r++)
            if (lf[r])
               for (int c = 0; c < 10; c++) begin
                  ei.push_back(r);
                  ej.push_back(c);
                  ed.push_back(p == 0 ? int'(pc) : 0);
               end

      line_full  = lf;
      piece_type = pc;
      enable     = 1'b1;
      tick;                         // enabling edge
      chk({name, " start read"}, int'(read), 1);
      idx    = 0;
      done_t = -1;
      for (int t = 1; t <= 600; t++) begin
         tick;
         if (read == 1'b0) begin
            if (idx < ei.size()) begin
               chk($sformatf("%s wr%0d pos_i", name, idx), int'(pos_i), ei[idx]);
               chk($sformatf("%s wr%0d pos_j", name, idx), int'(pos_j), ej[idx]);
               chk($sformatf("%s wr%0d data", name, idx), int'(write_data), ed[idx]);
            end else begin
               chk({name, " extra write"}, idx, ei.size());
            end
            idx++;
         end
         if (clear_line_done) begin
            done_t = t;
            break;
         end
         if (t == change_at) line_full = '0;
         if (t == abort_at) begin
            enable = 1'b0;
            tick;
            chk({name, " abort read"}, int'(read), 1);
            chk({name, " abort done"}, int'(clear_line_done), 0);
            $display("run %s: aborted after edge %0d, %0d writes seen", name, t, idx);
            return;
         end
      end
      chk({name, " done latency"}, done_t, 1 + 2 * (11 * n + 1));
      chk({name, " write count"}, idx, 2 * n * 10);
      tick;
      tick;
      chk({name, " done held"}, int'(clear_line_done), 1);
      chk({name, " done read"}, int'(read), 1);
      if (n > 0) chk({name, " pos_j held"}, int'(pos_j), 9);
      enable = 1'b0;
      tick;
      chk({name, " drop done"}, int'(clear_line_done), 0);
      chk({name, " drop read"}, int'(read), 1);
      tick;
      chk({name, " idle done"}, int'(clear_line_done), 0);
      $display("run %s: rows=%0d writes=%0d done_edge=%0d", name, n, idx, done_t);
   endtask

   initial begin
      logic [0:19] lf;

      // Reset held low with enable high: outputs stay at reset values.
      reset      = 1'b0;
      enable     = 1'b1;
      line_full  = 20'd1;
      piece_type = 3'd3;
      repeat (3) tick;
      chk("rst read", int'(read), 1);
      chk("rst done", int'(clear_line_done), 0);
      chk("rst pos_i", int'(pos_i), 0);
      chk("rst pos_j", int'(pos_j), 0);
      chk("rst wdata", int'(write_data), 0);
      enable = 1'b0;
      reset  = 1'b1;
      tick;
      chk("idle read", int'(read), 1);
      $display("reset check done");

      // Single bottom row (20'd1 -> row 19).
      run_seq("row19", 20'd1, 3'd3, -1, -1);
      // Same, with line_full removed seven edges in: mask is latched.
      run_seq("row19_latch", 20'd1, 3'd3, 7, -1);
      // Rows 2 and 17.
      lf = '0; lf[2] = 1'b1; lf[17] = 1'b1;
      run_seq("rows2_17", lf, 3'd5, -1, -1);
      // No full rows.
      run_seq("empty", 20'd0, 3'd4, -1, -1);
      // Top row only.
      lf = '0; lf[0] = 1'b1;
      run_seq("row0", lf, 3'd7, -1, -1);
      // Abort during pass-1 write, then restart from the first row.
      lf = '0; lf[2] = 1'b1; lf[17] = 1'b1;
      run_seq("abort", lf, 3'd6, -1, 5);
      run_seq("restart", lf, 3'd6, -1, -1);

      // Asynchronous reset in the middle of a write burst.
      line_full  = 20'd1;
      piece_type = 3'd2;
      enable     = 1'b1;
      repeat (5) tick;
      chk("mid wr read", int'(read), 0);
      #2;
      reset = 1'b0;
      #1;
      chk("async read", int'(read), 1);
      chk("async pos_i", int'(pos_i), 0);
      chk("async pos_j", int'(pos_j), 0);
      chk("async wdata", int'(write_data), 0);
      chk("async done", int'(clear_line_done), 0);
      enable = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      $display("async reset check done");

      // Clean run after the asynchronous reset.
      run_seq("post_rst", 20'd1, 3'd1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
